rr_select_stage: RTL
====================

Name: rr_select_stage

Overview:
- Upstream feeder for the 4-way signed select mux.
- Arbitrates round-robin among four handshaked sources: two unsigned (2b, 4b) and two signed (4b, 4b).
- Width-normalises the winning operand to a signed 5-bit value and registers it, together with the 2-bit source index that drives the mux select.
- Single-entry output register with valid/ready on both sides; 1-cycle latency, full throughput.

Parameters:
- U1_W, 2, width of unsigned source 0
- U2_W, 4, width of unsigned source 1
- S_W, 4, width of signed sources 2 and 3
- OUT_W, 5, output width; must be >= max(U1_W+1, U2_W+1, S_W); elaboration error otherwise

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- uin1  in  U1_W  unsigned source 0 data
- uin1_valid  in  1  source 0 valid
- uin1_ready  out  1  source 0 ready
- uin2 / uin2_valid / uin2_ready  in/in/out  U2_W/1/1  unsigned source 1
- sin1 / sin1_valid / sin1_ready  in/in/out  S_W/1/1  signed source 2
- sin2 / sin2_valid / sin2_ready  in/in/out  S_W/1/1  signed source 3
- out_data  out  OUT_W  signed normalised operand (registered)
- out_src  out  2  index of the source that produced out_data (registered; drives the mux select)
- out_valid  out  1  output register holds data
- out_ready  in  1  downstream accepts

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_src=0, rr_ptr=0; all *_ready=0 while rst_n=0.
- can_load = !out_valid || out_ready.
- Grant: combinational. Search from rr_ptr upward, modulo 4, for the first source with valid=1.
- Ready: only the granted source sees ready=1, and only when can_load=1. All others see 0.
- Ready does not depend on that source's own valid beyond the grant, so it is free of combinational loops.
- Transfer occurs when granted valid && ready. On that edge:
  - out_data <= normalised operand
  - out_src <= grant index
  - out_valid <= 1
  - rr_ptr <= grant+1 (mod 4)
- Normalisation: unsigned sources are zero-extended to OUT_W; signed sources are sign-extended. Example: sin1=4'b1000 -> 5'b11000 (-8); uin2=4'hF -> 5'b01111 (+15).
- No transfer and out_ready=1: out_valid <= 0. out_data and out_src hold their last value.
- No transfer and out_ready=0: register holds.
- Simultaneous drain and load (out_valid=1, out_ready=1, new grant): back-to-back, out_valid stays 1.
- No requests: rr_ptr unchanged.
- A source that loses arbitration must hold valid and data stable (standard valid/ready rule); the block does not buffer losers.
- Two-state control: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY -> FULL on transfer.
  - FULL -> EMPTY on out_ready with no transfer.
  - FULL -> FULL on stall, or on drain+load.
- Reset mid-transfer discards the held entry; rr_ptr returns to 0.

Optional Feature:
- Macro: RR_SELECT_STAGE_STATS_EN.
- With macro: adds output grant_cnt, 4x8 bits flattened as [31:0], with source i in bits [8i+7:8i].
  - Each field increments on a transfer from source i and saturates at 8'hFF.
  - Adds input stats_clr (1b): synchronous clear of all counters. Clear wins over a same-cycle increment.
  - Counters reset to 0.
- Without macro: neither port exists and no counter logic is generated. The rest of the behaviour is identical.

Decomposition:
- Shared package rr_select_pkg:
  - enum src_id_t {SRC_U1=0, SRC_U2=1, SRC_S1=2, SRC_S2=3}, 2 bits
  - localparam NUM_SRC=4
  - sign-flag constant per source: 0,0,1,1
- Sub-module rr_arbiter4:
  - inputs: req[3:0], ptr[1:0], en
  - outputs: gnt_onehot[3:0], gnt_idx[1:0], any
  - purely combinational; instantiated once.

Test Plan:
- Reset: hold rst_n=0 with all valids=1 -> all readys=0, out_valid=0, out_data=0, out_src=0. Assert rst_n low asynchronously mid-stream -> outputs clear before the next clk edge.
- Sign extension: only sin1_valid with sin1=4'h8 -> next cycle out_data=5'h18, out_src=2. Only uin2_valid with uin2=4'hF -> out_data=5'h0F, out_src=1. Only uin1_valid with uin1=2'b11 -> out_data=5'h03.
- Round-robin: all four valid, out_ready=1 -> out_src sequence 0,1,2,3,0 on consecutive cycles, out_valid continuously 1.
- Backpressure: out_ready=0 for 3 cycles with uin1_valid=1 -> out_data/out_src stable, uin1_ready=0 while FULL. Release out_ready -> entry drains and the next grant loads in the same cycle.
- Sparse requests: rr_ptr=2, only uin1_valid -> grant 0 and rr_ptr becomes 1. Then with no valids and out_ready=1 -> out_valid drops to 0 after one cycle.
- RR_SELECT_STAGE_STATS_EN: 300 transfers from sin2 -> grant_cnt[31:24]=8'hFF, other fields 0. stats_clr concurrent with a transfer -> all fields 0.

Source files
------------

// File: rtl/rr_select_pkg.sv
// Shared definitions for the round-robin select stage: source ids, source count,
// per-source signedness and the output-register state encoding.
package rr_select_pkg;

  localparam int NUM_SRC = 4;

  typedef enum logic [1:0] {
    SRC_U1 = 2'd0,
    SRC_U2 = 2'd1,
    SRC_S1 = 2'd2,
    SRC_S2 = 2'd3
  } src_id_t;

  // Bit i set means source i carries a two's-complement operand.
  localparam logic [NUM_SRC-1:0] SRC_IS_SIGNED = 4'b1100;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way combinational round-robin arbiter: the first requester at or above
// ptr (wrapping modulo 4) wins; the one-hot grant is suppressed when en is low.
module rr_arbiter4
  import rr_select_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [1:0]         ptr,
  input  logic               en,
  output logic [NUM_SRC-1:0] gnt_onehot,
  output logic [1:0]         gnt_idx,
  output logic               any
);

  always_comb begin
    gnt_idx = ptr;
    // Walk from the farthest candidate back to ptr so the nearest requester is kept.
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (req[ptr + 2'(k)]) gnt_idx = ptr + 2'(k);
    end
    any        = |req;
    gnt_onehot = '0;
    if (en && any) gnt_onehot[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/rr_select_stage.sv
// Round-robin feeder for the signed select mux: picks one of four sources, widens
// it to OUT_W signed, and registers it with its source index behind a valid/ready
// output register. Optional saturating per-source grant counters: RR_SELECT_STAGE_STATS_EN.
module rr_select_stage
  import rr_select_pkg::*;
#(
  parameter int U1_W  = 2,
  parameter int U2_W  = 4,
  parameter int S_W   = 4,
  parameter int OUT_W = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
`ifdef RR_SELECT_STAGE_STATS_EN
  input  logic                    stats_clr,
  output logic [31:0]             grant_cnt,
`endif
  input  logic [U1_W-1:0]         uin1,
  input  logic                    uin1_valid,
  output logic                    uin1_ready,
  input  logic [U2_W-1:0]         uin2,
  input  logic                    uin2_valid,
  output logic                    uin2_ready,
  input  logic [S_W-1:0]          sin1,
  input  logic                    sin1_valid,
  output logic                    sin1_ready,
  input  logic [S_W-1:0]          sin2,
  input  logic                    sin2_valid,
  output logic                    sin2_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic [1:0]              out_src,
  output logic                    out_valid,
  input  logic                    out_ready
);

  if ((OUT_W < U1_W + 1) || (OUT_W < U2_W + 1) || (OUT_W < S_W)) begin : g_bad_cfg
    $error("rr_select_stage: OUT_W too narrow for the configured source widths");
  end

  // Handshake: a source transfers on the rising edge where its valid and ready are
  // both high. Ready is the arbiter grant gated by can_load and never looks at the
  // source's own valid except through the grant, so no valid->ready loop exists.
  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] gnt_onehot;
  logic [1:0]         gnt_idx;
  logic               gnt_any;
  logic               can_load;
  logic               xfer;
  logic [OUT_W-1:0]   norm_data;

  logic [0:0]       state_q, state_d;
  logic [1:0]       rr_ptr_q, rr_ptr_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic [1:0]       out_src_q, out_src_d;

  assign req      = {sin2_valid, sin1_valid, uin2_valid, uin1_valid};
  assign can_load = (state_q == ST_EMPTY) || out_ready;

  rr_arbiter4 u_arb (
    .req        (req),
    .ptr        (rr_ptr_q),
    .en         (can_load && rst_n),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (gnt_any)
  );

  assign xfer       = gnt_any && (|gnt_onehot);
  assign uin1_ready = gnt_onehot[SRC_U1];
  assign uin2_ready = gnt_onehot[SRC_U2];
  assign sin1_ready = gnt_onehot[SRC_S1];
  assign sin2_ready = gnt_onehot[SRC_S2];

  always_comb begin
    norm_data = '0;
    case (gnt_idx)
      SRC_U1:  norm_data = OUT_W'(uin1);
      SRC_U2:  norm_data = OUT_W'(uin2);
      SRC_S1:  norm_data = SRC_IS_SIGNED[SRC_S1] ? OUT_W'($signed(sin1)) : OUT_W'(sin1);
      default: norm_data = SRC_IS_SIGNED[SRC_S2] ? OUT_W'($signed(sin2)) : OUT_W'(sin2);
    endcase
  end

  // A drain and a load in the same cycle keep the register FULL.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    out_data_d = out_data_q;
    out_src_d  = out_src_q;
    if (xfer) begin
      state_d    = ST_FULL;
      out_data_d = norm_data;
      out_src_d  = gnt_idx;
      rr_ptr_d   = gnt_idx + 2'd1;
    end else if (out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      rr_ptr_q   <= 2'd0;
      out_data_q <= '0;
      out_src_q  <= 2'd0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      out_data_q <= out_data_d;
      out_src_q  <= out_src_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

`ifdef RR_SELECT_STAGE_STATS_EN
  logic [7:0] cnt_q [NUM_SRC];

  // Clear takes priority over a same-cycle increment; counters stick at 8'hFF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SRC; i++) cnt_q[i] <= 8'd0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (stats_clr)
          cnt_q[i] <= 8'd0;
        else if (xfer && (gnt_idx == 2'(i)) && (cnt_q[i] != 8'hFF))
          cnt_q[i] <= cnt_q[i] + 8'd1;
      end
    end
  end

  assign grant_cnt = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`endif

endmodule
